// File: rtl/router_merge_pkg.sv
// Shared types and helpers for the N-way NoC output merge.
package router_merge_pkg;
  typedef enum logic [0:0] {IDLE, WAIT_IN} merge_state_t;

  localparam int MODE_CTRL = 0;
  localparam int MODE_RR   = 1;
  localparam int MAX_IN    = 16;

  // Returns {found, index}: first valid channel at or after ptr, wrapping mod n.
  function automatic logic [4:0] rr_pick(input logic [MAX_IN-1:0] valid,
                                         input logic [3:0] ptr, input int n);
    logic [4:0] r;
    int idx;
    r = '0;
    for (int k = MAX_IN - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (valid[idx]) r = {1'b1, 4'(idx)};
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; push/pop are self-gated by full/empty, head reads as zero when empty.
module sync_fifo #(
  parameter int DATA_W = 11,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/router_merge_nway_sync.sv
// N-input merge into an output FIFO, steered by control tokens (CTRL) or round-robin (RR).
module router_merge_nway_sync
  import router_merge_pkg::*;
#(
  parameter int NUM_IN  = 5,
  parameter int DATA_W  = 11,
  parameter int SEL_W   = 3,
  parameter int DEPTH   = 4,
  parameter int RR_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [SEL_W-1:0]         ctrl_sel,
  input  logic                     ctrl_valid,
  output logic                     ctrl_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sel_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int IDX_W = $clog2(NUM_IN);

  logic              push, full, empty;
  logic [DATA_W-1:0] push_data;
  logic [IDX_W-1:0]  src;

  assign out_valid = !empty;

  always_comb begin
    push_data = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (src == IDX_W'(i)) push_data = in_data[i*DATA_W +: DATA_W];
  end

  if (RR_MODE == MODE_RR) begin : g_rr
    logic [IDX_W-1:0] rr_ptr;
    logic [4:0]       pick;
    logic             unused_ok;

    assign pick       = rr_pick(MAX_IN'(in_valid), 4'(rr_ptr), NUM_IN);
    assign src        = IDX_W'(pick[3:0]);
    assign push       = pick[4] && !full;
    assign ctrl_ready = 1'b0;
    assign sel_err    = 1'b0;
    assign unused_ok  = ^{ctrl_sel, ctrl_valid, pick[3:0]};

    always_comb begin
      in_ready = '0;
      for (int i = 0; i < NUM_IN; i++) in_ready[i] = push && (src == IDX_W'(i));
    end

    always_ff @(posedge clk) begin
      if (reset)     rr_ptr <= '0;
      else if (push) rr_ptr <= (src == IDX_W'(NUM_IN - 1)) ? '0 : src + 1'b1;
    end
  end else begin : g_ctrl
    merge_state_t     state;
    logic [SEL_W-1:0] sel_q;
    logic             ctrl_rdy_q, sel_err_q;

    assign src        = IDX_W'(sel_q);
    assign ctrl_ready = ctrl_rdy_q;
    assign sel_err    = sel_err_q;

    // Ready to the selected input only; never looks at in_valid.
    always_comb begin
      in_ready = '0;
      for (int i = 0; i < NUM_IN; i++)
        in_ready[i] = (state == WAIT_IN) && !full && (src == IDX_W'(i));
    end
    assign push = |(in_ready & in_valid);

    always_ff @(posedge clk) begin
      if (reset) begin
        state      <= IDLE;
        sel_q      <= '0;
        ctrl_rdy_q <= 1'b0;
        sel_err_q  <= 1'b0;
      end else begin
        sel_err_q <= 1'b0;
        case (state)
          IDLE: begin
            ctrl_rdy_q <= 1'b1;
            if (ctrl_rdy_q && ctrl_valid) begin
              if ({1'b0, ctrl_sel} < (SEL_W+1)'(NUM_IN)) begin
                sel_q      <= ctrl_sel;
                state      <= WAIT_IN;
                ctrl_rdy_q <= 1'b0;
              end else begin
                sel_err_q <= 1'b1;
              end
            end
          end
          WAIT_IN: begin
            if (push) begin
              state      <= IDLE;
              ctrl_rdy_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (out_ready),
    .wdata (push_data),
    .rdata (out_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_router_merge_nway_sync.sv
// Random and directed checks of both merge modes against queue-based reference models.
module tb_router_merge_nway_sync;
  localparam int N = 5, DW = 11, SW = 3, D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N*DW-1:0] c_in_data, r_in_data;
  logic [N-1:0]    c_in_valid, c_in_ready, r_in_valid, r_in_ready;
  logic [SW-1:0]   c_ctrl_sel, r_ctrl_sel;
  logic            c_ctrl_valid, c_ctrl_ready, r_ctrl_valid, r_ctrl_ready;
  logic [DW-1:0]   c_out_data, r_out_data;
  logic            c_out_valid, c_out_ready, r_out_valid, r_out_ready;
  logic            c_sel_err, r_sel_err;
  logic [2:0]      c_fifo_count, r_fifo_count;

  router_merge_nway_sync #(.NUM_IN(N), .DATA_W(DW), .SEL_W(SW), .DEPTH(D), .RR_MODE(0)) u_ctrl (
    .clk(clk), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .ctrl_sel(c_ctrl_sel), .ctrl_valid(c_ctrl_valid), .ctrl_ready(c_ctrl_ready),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .sel_err(c_sel_err), .fifo_count(c_fifo_count));

  router_merge_nway_sync #(.NUM_IN(N), .DATA_W(DW), .SEL_W(SW), .DEPTH(D), .RR_MODE(1)) u_rr (
    .clk(clk), .reset(reset), .in_data(r_in_data), .in_valid(r_in_valid), .in_ready(r_in_ready),
    .ctrl_sel(r_ctrl_sel), .ctrl_valid(r_ctrl_valid), .ctrl_ready(r_ctrl_ready),
    .out_data(r_out_data), .out_valid(r_out_valid), .out_ready(r_out_ready),
    .sel_err(r_sel_err), .fifo_count(r_fifo_count));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference state: FIFO contents as queues, CTRL token progress, RR pointer.
  logic [DW-1:0] cq[$], rq[$], rr_seen[$];
  bit c_wait, c_rdy, c_err;
  int c_sel, r_ptr;

  function automatic logic [DW-1:0] chan(input logic [N*DW-1:0] d, input int i);
    return d[i*DW +: DW];
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    cq.delete(); rq.delete();
    c_wait = 0; c_rdy = 0; c_err = 0; c_sel = 0; r_ptr = 0;
  endtask

  // Inputs are driven at posedge+1; outputs checked at posedge+3; model advanced for the next edge.
  task automatic c_cycle();
    logic [N-1:0] er;
    bit fullb, nerr;
    #2;
    fullb = cq.size() >= D;
    er = '0;
    if (c_wait && !fullb) er[c_sel] = 1'b1;
    chk("c_ctrl_ready", 32'(c_ctrl_ready), 32'(c_rdy));
    chk("c_in_ready",   32'(c_in_ready),   32'(er));
    chk("c_sel_err",    32'(c_sel_err),    32'(c_err));
    chk("c_out_valid",  32'(c_out_valid),  32'(cq.size() != 0));
    chk("c_out_data",   32'(c_out_data),   (cq.size() != 0) ? 32'(cq[0]) : 32'd0);
    chk("c_fifo_count", 32'(c_fifo_count), 32'(cq.size()));
    nerr = 0;
    if (c_out_ready && cq.size() != 0) void'(cq.pop_front());
    if (c_wait) begin
      if (!fullb && c_in_valid[c_sel]) begin
        cq.push_back(chan(c_in_data, c_sel));
        c_wait = 0;
        c_rdy = 1;
      end
    end else if (!c_rdy) begin
      c_rdy = 1;
    end else if (c_ctrl_valid) begin
      if (int'(c_ctrl_sel) < N) begin
        c_wait = 1; c_sel = int'(c_ctrl_sel); c_rdy = 0;
      end else nerr = 1;
    end
    c_err = nerr;
    @(posedge clk); #1;
  endtask

  task automatic r_cycle();
    logic [N-1:0] er;
    int g;
    #2;
    g = -1;
    if (rq.size() < D)
      for (int k = 0; k < N; k++) begin
        int i;
        i = (r_ptr + k) % N;
        if (r_in_valid[i] && g < 0) g = i;
      end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("r_in_ready",   32'(r_in_ready),   32'(er));
    chk("r_out_valid",  32'(r_out_valid),  32'(rq.size() != 0));
    chk("r_out_data",   32'(r_out_data),   (rq.size() != 0) ? 32'(rq[0]) : 32'd0);
    chk("r_fifo_count", 32'(r_fifo_count), 32'(rq.size()));
    chk("r_ctrl_ready", 32'(r_ctrl_ready), 32'd0);
    chk("r_sel_err",    32'(r_sel_err),    32'd0);
    if (r_out_valid && r_out_ready) rr_seen.push_back(r_out_data);
    if (r_out_ready && rq.size() != 0) void'(rq.pop_front());
    if (g >= 0) begin
      rq.push_back(chan(r_in_data, g));
      r_ptr = (g + 1) % N;
    end
    @(posedge clk); #1;
  endtask

  task automatic c_send(input int sel);
    c_ctrl_sel = SW'(sel); c_ctrl_valid = 1'b1;
    c_cycle();
    c_ctrl_valid = 1'b0;
    c_cycle();
  endtask

  initial begin
    c_in_data = '0; c_in_valid = '0; c_ctrl_sel = '0; c_ctrl_valid = 1'b0; c_out_ready = 1'b0;
    r_in_data = '0; r_in_valid = '0; r_ctrl_sel = '0; r_ctrl_valid = 1'b0; r_out_ready = 1'b0;
    do_reset();
    c_cycle(); c_cycle();

    // Token sel=3 while in0..in3 all valid: only in3 may move.
    for (int i = 0; i < N; i++) c_in_data[i*DW +: DW] = DW'(11'h100 + i);
    c_in_data[3*DW +: DW] = 11'h5A5;
    c_in_valid = 5'b01111;
    c_send(3);
    chk("sel3_data",  32'(c_out_data),   32'h5A5);
    chk("sel3_count", 32'(c_fifo_count), 32'd1);
    c_in_valid = '0; c_out_ready = 1'b1;
    c_cycle();

    // Out-of-range select: one-cycle error pulse, then normal operation resumes.
    c_ctrl_sel = 3'd6; c_ctrl_valid = 1'b1;
    c_cycle();
    c_ctrl_valid = 1'b0;
    chk("selerr_pulse", 32'(c_sel_err), 32'd1);
    c_cycle(); c_cycle();
    c_in_valid = 5'b00001;
    c_send(0);
    c_cycle();

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N; i++) c_in_data[i*DW +: DW] = DW'($urandom);
      c_in_valid   = N'($urandom);
      c_ctrl_valid = 1'($urandom);
      c_ctrl_sel   = SW'($urandom_range(0, 7));
      c_out_ready  = ($urandom_range(0, 3) != 0);
      c_cycle();
    end

    // Reset while waiting on in2 with two flits buffered.
    c_ctrl_valid = 1'b0; c_in_valid = '0;
    do_reset();
    c_out_ready = 1'b0;
    c_cycle();
    c_in_valid = 5'b11011;
    c_send(0); c_send(1);
    c_send(2);
    chk("prerst_count", 32'(c_fifo_count), 32'd2);
    do_reset();
    chk("rst_out_valid",  32'(c_out_valid),  32'd0);
    chk("rst_fifo_count", 32'(c_fifo_count), 32'd0);
    chk("rst_ctrl_ready", 32'(c_ctrl_ready), 32'd0);
    c_in_valid = 5'b00100;
    repeat (4) c_cycle();
    chk("rst_no_consume", 32'(c_fifo_count), 32'd0);

    // RR: all inputs valid, drain every cycle.
    do_reset();
    for (int i = 0; i < N; i++) r_in_data[i*DW +: DW] = DW'(11'h100 + i);
    r_in_valid = '1; r_out_ready = 1'b1;
    rr_seen.delete();
    repeat (8) r_cycle();
    chk("rr_rate", 32'(rr_seen.size()), 32'd7);
    for (int k = 0; k < 6; k++)
      if (k < rr_seen.size()) chk("rr_order", 32'(rr_seen[k]), 32'(11'h100 + (k % N)));

    // RR backpressure until full, then a single-cycle pop.
    do_reset();
    r_out_ready = 1'b0;
    repeat (6) r_cycle();
    chk("bp_count_full", 32'(r_fifo_count), 32'd4);
    chk("bp_ready_low",  32'(r_in_ready),   32'd0);
    r_out_ready = 1'b1;
    r_cycle();
    r_out_ready = 1'b0;
    chk("bp_after_pop", 32'(r_fifo_count), 32'd3);
    r_cycle();
    chk("bp_refill", 32'(r_fifo_count), 32'd4);

    // Simultaneous push and pop at count 1.
    do_reset();
    r_in_valid = 5'b00010; r_out_ready = 1'b0;
    r_cycle();
    r_in_data[1*DW +: DW] = 11'h1AA; r_out_ready = 1'b1;
    r_cycle();
    chk("pp_count", 32'(r_fifo_count), 32'd1);
    chk("pp_data",  32'(r_out_data),   32'h1AA);

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N; i++) r_in_data[i*DW +: DW] = DW'($urandom);
      r_in_valid  = N'($urandom);
      r_out_ready = ($urandom_range(0, 2) != 0);
      r_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
